// File: rtl/mips_pkg.sv
`default_nettype none
// =============================================================================
// mips_pkg: shared widths and arbiter state encoding for the memory subsystem.
// Revision: 1.0
// =============================================================================
package mips_pkg;

   localparam int MIPS_ADDR_W = 32;
   localparam int MIPS_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_I = 2'd1,
      ST_GRANT_D = 2'd2,
      ST_RESP    = 2'd3
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// =============================================================================
// mem_arbiter_if: IF/MEM requester buses plus the shared memory port.
// Revision: 1.0
// =============================================================================
interface mem_arbiter_if
   import mips_pkg::*;
#(
   parameter int ADDR_W = MIPS_ADDR_W,
   parameter int DATA_W = MIPS_DATA_W
) ();

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_kill;
   logic [DATA_W-1:0] if_rdata;
   logic              if_stall;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_stall;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   // Arbiter side: serves the pipeline requesters and drives the memory port.
   modport slave (
      input  if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata,
      input  mem_rdata, mem_ack,
      output if_rdata, if_stall, d_rdata, d_stall,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata,
      output mem_rdata, mem_ack,
      input  if_rdata, if_stall, d_rdata, d_stall,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// mem_arbiter: shares one memory port between instruction fetch and MEM stage.
// Revision: 1.0
// =============================================================================
module mem_arbiter
   import mips_pkg::*;
#(
   parameter int ADDR_W     = MIPS_ADDR_W,
   parameter int DATA_W     = MIPS_DATA_W,
   parameter int STARVE_MAX = 4
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   localparam int               CNT_W        = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

   arb_state_t        state_q, state_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              kill_q, kill_d;
   logic              done_i_q, done_i_d;
   logic              done_d_q, done_d_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic              kill_now;
   logic              pick_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         starve_q   <= '0;
         kill_q     <= 1'b0;
         done_i_q   <= 1'b0;
         done_d_q   <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         kill_q     <= kill_d;
         done_i_q   <= done_i_d;
         done_d_q   <= done_d_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      starve_d      = starve_q;
      kill_d        = 1'b0;
      done_i_d      = 1'b0;
      done_d_d      = 1'b0;
      if_rdata_d    = if_rdata_q;
      d_rdata_d     = d_rdata_q;
      mem_addr_d    = '0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      // A kill arriving in the ack cycle must still suppress the fetch result.
      kill_now      = kill_q | bus.if_kill;
      pick_i        = bus.if_req & (~bus.d_req | (starve_q == C_STARVE_MAX));

      case (state_q)
         ST_IDLE: begin
            if (pick_i) begin
               state_d  = ST_GRANT_I;
               starve_d = '0;
            end else if (bus.d_req) begin
               state_d = ST_GRANT_D;
               if (bus.if_req && (starve_q != C_STARVE_MAX)) begin
                  starve_d = starve_q + 1'b1;
               end
            end
         end
         ST_GRANT_I: begin
            bus.mem_req = 1'b1;
            mem_addr_d  = bus.if_addr;
            kill_d      = kill_now;
            if (bus.mem_ack) begin
               state_d = ST_RESP;
               if (!kill_now) begin
                  done_i_d   = 1'b1;
                  if_rdata_d = bus.mem_rdata;
               end
            end
         end
         ST_GRANT_D: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = bus.d_we;
            mem_addr_d    = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            if (bus.mem_ack) begin
               state_d  = ST_RESP;
               done_d_d = 1'b1;
               if (!bus.d_we) begin
                  d_rdata_d = bus.mem_rdata;
               end
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.mem_addr = mem_addr_d;
   assign bus.if_rdata = if_rdata_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.if_stall = bus.if_req & ~done_i_q;
   assign bus.d_stall  = bus.d_req & ~done_d_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// =============================================================================
// tb_mem_arbiter: directed stimulus against a transaction-level arbiter model.
// Revision: 1.0
// =============================================================================
module tb_mem_arbiter;

   localparam int STARVE = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_s(input string nm, input string act, input string exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got '%s' want '%s'", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] rdata_for(input logic [31:0] a);
      return (a == 32'h40) ? 32'h8C01_0004 : {16'hC0DE, a[15:0]};
   endfunction

   // Memory responder: acks after lat idle cycles of mem_req, one-cycle pulse.
   int          lat = 0;
   int          wcnt = 0;
   int          n_ack = 0;
   logic        ack_r = 1'b0;
   logic [31:0] rd_r = '0;
   logic        spur = 1'b0;
   logic [31:0] spur_data = '0;

   assign bus.mem_ack   = ack_r | spur;
   assign bus.mem_rdata = spur ? spur_data : rd_r;

   always @(negedge clk) begin
      if (ack_r) begin
         ack_r = 1'b0;
      end else if (bus.mem_req) begin
         if (wcnt >= lat) begin
            ack_r = 1'b1;
            rd_r  = rdata_for(bus.mem_addr);
            wcnt  = 0;
            n_ack++;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   // Model: who owns the port, whether we are in the completion cycle, and
   // the architectural results each requester should have seen.
   int          m_owner = 0;     // 0 none, 1 fetch, 2 data
   bit          m_resp = 0;
   int          m_starve = 0;
   bit          m_killed = 0;
   bit          m_done_i = 0;
   bit          m_done_d = 0;
   logic [31:0] m_ifdata = '0;
   logic [31:0] m_ddata = '0;
   bit          m_valid = 0;
   string       glog = "";

   always @(posedge clk) begin
      if (reset) begin
         m_owner = 0; m_resp = 0; m_starve = 0; m_killed = 0;
         m_done_i = 0; m_done_d = 0; m_ifdata = '0; m_ddata = '0;
      end else begin
         m_done_i = 0;
         m_done_d = 0;
         if (m_resp) begin
            m_resp = 0;
         end else if (m_owner == 0) begin
            if (bus.if_req && (!bus.d_req || m_starve == STARVE)) begin
               m_owner = 1; m_starve = 0; m_killed = 0;
               glog = {glog, "I"};
            end else if (bus.d_req) begin
               m_owner = 2;
               if (bus.if_req && m_starve < STARVE) m_starve++;
               glog = {glog, "D"};
            end
         end else begin
            if (m_owner == 1 && bus.if_kill) m_killed = 1;
            if (bus.mem_ack) begin
               if (m_owner == 1) begin
                  if (!m_killed) begin
                     m_ifdata = bus.mem_rdata;
                     m_done_i = 1;
                  end
               end else begin
                  if (!bus.d_we) m_ddata = bus.mem_rdata;
                  m_done_d = 1;
               end
               m_owner = 0;
               m_resp  = 1;
            end
         end
      end
      m_valid = 1;
   end

   always @(negedge clk) begin
      #4;
      if (m_valid) begin
         chk("mem_req", {31'b0, bus.mem_req}, {31'b0, m_owner != 0});
         chk("mem_we", {31'b0, bus.mem_we}, {31'b0, m_owner == 2 && bus.d_we});
         if (m_owner == 1) chk("mem_addr_i", bus.mem_addr, bus.if_addr);
         if (m_owner == 2) begin
            chk("mem_addr_d", bus.mem_addr, bus.d_addr);
            chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
         end
         chk("if_stall", {31'b0, bus.if_stall}, {31'b0, bus.if_req && !m_done_i});
         chk("d_stall", {31'b0, bus.d_stall}, {31'b0, bus.d_req && !m_done_d});
         chk("if_rdata", bus.if_rdata, m_ifdata);
         chk("d_rdata", bus.d_rdata, m_ddata);
      end
   end

   task automatic wait_low(input bit is_d, input string nm);
      int k;
      for (k = 0; k < 60; k++) begin
         @(negedge clk);
         if (!(is_d ? bus.d_stall : bus.if_stall)) break;
      end
      n_cmp++;
      if (k == 60) begin
         n_bad++;
         $display("FAIL %s: stall got 1 want 0 (timeout)", nm);
      end
   endtask

   // Holds both requests, dropping each once its stall clears; counts D loads.
   task automatic run_both(input string nm, input int max_loads, output int loads, output bit ifgap);
      int k;
      loads = 0;
      ifgap = 0;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.d_req && !bus.d_stall) begin
            loads++;
            if (loads >= max_loads) bus.d_req = 1'b0;
            else bus.d_addr = 32'h300 + 32'(4 * loads);
         end else if (bus.d_req && !bus.if_stall) begin
            ifgap = 1;
         end
         if (bus.if_req && !bus.if_stall) bus.if_req = 1'b0;
         if (!bus.if_req && !bus.d_req) break;
      end
      n_cmp++;
      if (k == 200) begin
         n_bad++;
         $display("FAIL %s: requests still pending got 1 want 0 (timeout)", nm);
      end
   endtask

   initial begin
      int  loads;
      bit  ifgap;
      int  acks0;
      bus.if_req = 0; bus.if_addr = '0; bus.if_kill = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
      chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
      chk("rst_if_rdata", bus.if_rdata, 32'd0);
      chk("rst_d_rdata", bus.d_rdata, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Fetch, zero-latency memory: minimum service timing.
      bus.if_req = 1; bus.if_addr = 32'h40; lat = 0;
      @(negedge clk);
      chk("f_c1_mem_req", {31'b0, bus.mem_req}, 32'd1);
      chk("f_c1_if_stall", {31'b0, bus.if_stall}, 32'd1);
      @(negedge clk);
      chk("f_c2_if_stall", {31'b0, bus.if_stall}, 32'd0);
      chk("f_if_rdata", bus.if_rdata, 32'h8C01_0004);
      bus.if_req = 0;
      @(negedge clk);

      // Store, with a stray kill during GRANT_D.
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF; lat = 1;
      @(negedge clk);
      chk("st_mem_we", {31'b0, bus.mem_we}, 32'd1);
      chk("st_mem_addr", bus.mem_addr, 32'h200);
      chk("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      bus.if_kill = 1;
      @(negedge clk);
      bus.if_kill = 0;
      wait_low(1, "st_done");
      chk("st_d_rdata", bus.d_rdata, 32'd0);
      bus.d_req = 0; bus.d_we = 0;
      @(negedge clk);

      // Simultaneous requests.
      glog = "";
      bus.if_req = 1; bus.if_addr = 32'h44; bus.d_req = 1; bus.d_addr = 32'h100; lat = 2;
      run_both("sim_run", 1, loads, ifgap);
      chk_s("sim_order", glog, "DI");
      chk("sim_if_gap", {31'b0, ifgap}, 32'd0);
      chk("sim_d_rdata", bus.d_rdata, 32'hC0DE_0100);
      chk("sim_if_rdata", bus.if_rdata, 32'hC0DE_0044);
      @(negedge clk);

      // Starvation: five back-to-back loads with a fetch waiting.
      glog = "";
      bus.if_req = 1; bus.if_addr = 32'h80; bus.d_req = 1; bus.d_addr = 32'h300; lat = 0;
      run_both("stv_run", 5, loads, ifgap);
      chk_s("stv_order", glog, "DDDDID");
      chk("stv_loads", 32'(loads), 32'd5);
      chk("stv_d_rdata", bus.d_rdata, 32'hC0DE_0310);
      chk("stv_if_rdata", bus.if_rdata, 32'hC0DE_0080);
      @(negedge clk);

      // Kill during GRANT_I; the fetch is re-issued while if_req stays high.
      glog = ""; acks0 = n_ack;
      bus.if_req = 1; bus.if_addr = 32'h60; lat = 3;
      @(negedge clk);
      bus.if_kill = 1;
      @(negedge clk);
      bus.if_kill = 0;
      wait_low(0, "kill_done");
      chk_s("kill_grants", glog, "II");
      chk("kill_acks", 32'(n_ack - acks0), 32'd2);
      chk("kill_if_rdata", bus.if_rdata, 32'hC0DE_0060);
      bus.if_req = 0;
      @(negedge clk);

      // Spurious ack while idle.
      spur_data = 32'h1234_5678; spur = 1;
      @(negedge clk);
      spur = 0;
      @(negedge clk);
      chk("spur_if_rdata", bus.if_rdata, 32'hC0DE_0060);
      chk("spur_d_rdata", bus.d_rdata, 32'hC0DE_0310);

      // Reset while in GRANT_D.
      glog = "";
      bus.d_req = 1; bus.d_addr = 32'h140; bus.if_req = 1; bus.if_addr = 32'h90; lat = 5;
      @(negedge clk);
      chk("rg_mem_req", {31'b0, bus.mem_req}, 32'd1);
      reset = 1;
      @(negedge clk);
      chk("rg_mem_req_after", {31'b0, bus.mem_req}, 32'd0);
      chk("rg_if_stall", {31'b0, bus.if_stall}, 32'd1);
      chk("rg_d_stall", {31'b0, bus.d_stall}, 32'd1);
      chk("rg_if_rdata", bus.if_rdata, 32'd0);
      reset = 0;
      run_both("rg_run", 1, loads, ifgap);
      chk_s("rg_order", glog, "DDI");
      chk("rg_d_rdata", bus.d_rdata, 32'hC0DE_0140);
      chk("rg_if_rdata_end", bus.if_rdata, 32'hC0DE_0090);
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: got still running want finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
